dotp_mac_engine: RTL and testbench

Downstream consumer of the shared-memory word RAM. It streams a run of 128-bit RAM words, each packed with 8 signed 16-bit shorts (4 operand pairs). It multiplies the 4 pairs in parallel on 4 DSP lanes and accumulates one signed dot product per run. The result is returned to the HPS-facing control logic over a valid/ready handshake.

---
 rtl/dotp_pkg.sv | 9 +
 rtl/dotp_lane_mul.sv | 11 +
 rtl/dotp_mac_engine.sv | 96 +++++++++
 tb/tb_dotp_mac_engine.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dotp_pkg.sv
// dotp_pkg: shared state type, pipeline depth, default accumulator width and lane-slicing helper for dotp_mac_engine
package dotp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int PIPE_LATENCY = 4;
  localparam int DOTP_ACC_WIDTH = 48;
  function automatic int lane_lo(input int k, input int w);
    return 2 * w * k;
  endfunction
endpackage

// File: rtl/dotp_lane_mul.sv
// dotp_lane_mul: registered signed WIDTH x WIDTH multiply, one DSP lane
module dotp_lane_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);
  always_ff @(posedge clk) p <= $signed(a) * $signed(b);
endmodule

// File: rtl/dotp_mac_engine.sv
// dotp_mac_engine: streamed 4-lane signed dot product over RAM words; DOTP_SATURATE_EN selects saturating accumulation
module dotp_mac_engine
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = DOTP_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  overflow
);
  localparam int SUM_W = 2 * LANE_WIDTH + $clog2(LANES);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [ADDR_WIDTH:0] cnt;
  logic [PIPE_LATENCY-2:0] vld;
  logic accept, ovf_n;
  logic signed [2*LANE_WIDTH-1:0] prod [LANES];
  logic signed [SUM_W-1:0] sum_n, sum_q;
  logic signed [ACC_WIDTH:0] wide;
  logic signed [ACC_WIDTH-1:0] acc, acc_n;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int LO = lane_lo(k, LANE_WIDTH);
    dotp_lane_mul #(.WIDTH(LANE_WIDTH)) u_mul (
      .clk (clk),
      .a   (ram_q[LO +: LANE_WIDTH]),
      .b   (ram_q[LO+LANE_WIDTH +: LANE_WIDTH]),
      .p   (prod[k])
    );
  end
  assign accept = start && (state == IDLE || (state == DONE && result_ready));
  assign result_valid = state == DONE;
  assign busy = state != IDLE && !(result_valid && result_ready);
  assign result = acc;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = accept ? (word_count == '0 ? DONE : RUN)
            : state == RUN   ? (cnt == (ADDR_WIDTH+1)'(1) ? DRAIN : RUN)
            : state == DRAIN ? (vld[0] || vld[1] ? DRAIN : DONE)
            : state == DONE  ? (result_ready ? IDLE : DONE)
            : IDLE;
  end
  always_comb begin
    sum_n = '0;
    for (int i = 0; i < LANES; i++) sum_n = sum_n + SUM_W'(prod[i]);
    wide = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(sum_q);
    ovf_n = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
`ifdef DOTP_SATURATE_EN
    acc_n = ovf_n ? (wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX) : wide[ACC_WIDTH-1:0];
`else
    acc_n = wide[ACC_WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      ram_addr <= '0;
      cnt      <= '0;
      vld      <= '0;
      sum_q    <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      vld   <= {vld[PIPE_LATENCY-3:0], state == RUN};
      sum_q <= sum_n;
      if (accept) begin
        cnt      <= word_count;
        acc      <= '0;
        overflow <= 1'b0;
        if (word_count != '0) ram_addr <= base_addr;
      end else begin
        if (state == RUN) begin
          cnt <= cnt - 1'b1;
          if (cnt != (ADDR_WIDTH+1)'(1)) ram_addr <= ram_addr + 1'b1;
        end
        if (vld[PIPE_LATENCY-2]) begin
          acc      <= acc_n;
          overflow <= overflow | ovf_n;
        end
      end
    end
endmodule

// File: tb/tb_dotp_mac_engine.sv
// tb_dotp_mac_engine: randomized self-checking bench against an arithmetic dot-product model at 48- and 34-bit accumulator widths
module tb_dotp_mac_engine;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, result_ready = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] word_count = '0;
  logic busy_a, busy_b, rv_a, rv_b, ovf_a, ovf_b;
  logic [5:0] addr_a, addr_b;
  logic [127:0] q_a, q_b;
  logic [47:0] res_a;
  logic [33:0] res_b;
  logic [127:0] mem [64];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  dotp_mac_engine u_a (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy_a), .ram_addr(addr_a), .ram_q(q_a), .result(res_a), .result_valid(rv_a),
    .result_ready(result_ready), .overflow(ovf_a)
  );
  dotp_mac_engine #(.ACC_WIDTH(34)) u_b (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy_b), .ram_addr(addr_b), .ram_q(q_b), .result(res_b), .result_valid(rv_b),
    .result_ready(result_ready), .overflow(ovf_b)
  );
  always @(posedge clk) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] pack(input int a0, b0, a1, b1, a2, b2, a3, b3);
    return {16'(b3), 16'(a3), 16'(b2), 16'(a2), 16'(b1), 16'(a1), 16'(b0), 16'(a0)};
  endfunction
  function automatic longint word_sum(input logic [127:0] w);
    longint s;
    s = 0;
    for (int k = 0; k < 4; k++)
      s += longint'($signed(w[32*k +: 16])) * longint'($signed(w[32*k+16 +: 16]));
    return s;
  endfunction
  function automatic logic [63:0] model(input int base, input int cnt, input int w, output logic ovf);
    longint acc, mx, mn, s;
    acc = 0;
    mx = (64'sd1 <<< (w-1)) - 1;
    mn = -(64'sd1 <<< (w-1));
    ovf = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      s = acc + word_sum(mem[(base+i)%64]);
      if (s > mx || s < mn) begin
        ovf = 1'b1;
`ifdef DOTP_SATURATE_EN
        s = s > mx ? mx : mn;
`else
        s = ((s - mn) & ((64'sd1 <<< w) - 1)) + mn;
`endif
      end
      acc = s;
    end
    return 64'(acc) & ((64'd1 << w) - 1);
  endfunction
  task automatic run(input int base, input int cnt, input int hold, input bit poke);
    logic [63:0] ea, eb;
    logic oa, ob;
    logic [47:0] held;
    logic [5:0] a0, ah;
    int lat, want;
    ea = model(base, cnt, 48, oa);
    eb = model(base, cnt, 34, ob);
    @(negedge clk);
    a0 = addr_a;
    base_addr = 6'(base);
    word_count = 7'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
    lat = 0;
    want = cnt == 0 ? 0 : cnt + 3;
    while (!rv_a && lat < 200) begin
      if (lat < cnt) chk("ram_addr", addr_a, 64'((base + lat) % 64));
      @(negedge clk);
      lat++;
    end
    if (cnt == 0) chk("zero_len_addr", addr_a, a0);
    chk("latency", lat, want);
    chk("result_48", res_a, ea);
    chk("overflow_48", ovf_a, oa);
    chk("valid_34", rv_b, 1);
    chk("result_34", res_b, eb);
    chk("overflow_34", ovf_b, ob);
    held = res_a;
    ah = addr_a;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == hold / 2) begin
        base_addr = 6'($urandom);
        word_count = 7'($urandom_range(1, 64));
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chk("hold_result", res_a, held);
      chk("hold_busy", busy_a, 1);
      chk("hold_valid", rv_a, 1);
      chk("hold_addr", addr_a, ah);
    end
    result_ready = 1'b1;
    #1;
    chk("handshake_busy", busy_a, 0);
    chk("handshake_valid", rv_a, 1);
    @(negedge clk);
    result_ready = 1'b0;
    chk("idle_busy", busy_a, 0);
    chk("idle_valid", rv_a, 0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", rv_a, 0);
    chk("rst_result", res_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_addr", addr_a, 0);
    reset = 1'b0;
    mem[0] = pack(3, 4, -2, 5, 7, -1, 0, 9);
    run(0, 1, 2, 0);
    for (int i = 0; i < 4; i++) mem[(62 + i) % 64] = pack(1, 1, 1, 1, 1, 1, 1, 1);
    run(62, 4, 0, 0);
    run(5, 0, 1, 0);
    run(7, 3, 10, 1);
    @(negedge clk);
    base_addr = 6'd20;
    word_count = 7'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_valid", rv_a, 0);
    chk("midrst_result", res_a, 0);
    chk("midrst_overflow", ovf_a, 0);
    chk("midrst_addr", addr_a, 0);
    chk("midrst_result_34", res_b, 0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = pack(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    run(10, 2, 0, 0);
    run(0, 64, 0, 0);
    repeat (12) begin
      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      run(int'($urandom_range(0, 63)), int'($urandom_range(1, 64)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
